inst_cache: RTL and testbench
=============================

Name: inst_cache

Overview:
- Instruction-side responder for the fetch stage.
- Accepts the fetch PC and returns the instruction word in the same cycle on a hit.
- On a miss, asserts a stall back to fetch and refills a direct-mapped line from the backing instruction memory over a req/ack beat handshake.
- Sits between the fetch stage and the instruction ROM/RAM.

Parameters:
- WORD, 32, instruction/data word width.
- ADDR, 32, word-address width; PC increments by 1 per instruction.
- LINES, 16, number of cache lines; power of 2.
- LINE_WORDS, 4, words per line; power of 2, ≥2.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- req_i  in  1  fetch lookup valid.
- pc_i  in  ADDR  fetch word address.
- inst_o  out  WORD  instruction for pc_i; 0 when not hit.
- stall_o  out  1  to fetch stall input; high = inst_o not valid, hold PC.
- inval_i  in  1  invalidate all lines (one-cycle pulse).
- mem_req_o  out  1  backing read request, held until ack.
- mem_addr_o  out  ADDR  backing word address.
- mem_ack_i  in  1  beat accepted; mem_data_i valid this cycle.
- mem_data_i  in  WORD  backing read data.
- hit_cnt_o  out  32  hit counter (optional feature).
- miss_cnt_o  out  32  miss counter (optional feature).

Behaviour:
- Address split: off = pc_i[log2(LINE_WORDS)-1:0]; idx = next log2(LINES) bits; tag = remaining upper bits.
- Storage: flop arrays valid[LINES], tag[LINES], data[LINES][LINE_WORDS]. Read is combinational.
- hit = req_i & valid[idx] & tag[idx]==tag & state==IDLE.
- inst_o = hit ? data[idx][off] : 0.
- stall_o = req_i & ~hit (combinational, zero latency).
- FSM states:
  - IDLE: on req_i & ~hit, latch line base {tag,idx,0}, clear beat counter, clear valid[idx], go to REFILL.
  - REFILL: mem_req_o=1, mem_addr_o = base + beat. On mem_ack_i, write mem_data_i to data[idx][beat]. If beat==LINE_WORDS-1, go to DONE; else beat+1.
  - DONE: set valid[idx] and tag[idx]; stall_o stays 1; go to IDLE. The first hit on the line is the cycle after DONE.
- Miss penalty with single-cycle acks: LINE_WORDS + 2 stall cycles.
- mem_req_o and mem_addr_o are registered outputs and stable while waiting for ack. mem_ack_i is ignored outside REFILL.
- pc_i changes during refill (branch redirect): the refill still completes into the latched line. Lookup resumes with the current pc_i in IDLE.
- inval_i:
  - In IDLE: clears all valid bits at the next edge.
  - In REFILL/DONE: clears all lines except the one being filled, which still completes.
  - Coincident with a DONE-cycle tag write: the new line survives.
- Reset (any state, including mid-refill): valid all 0, FSM IDLE, beat 0, mem_req_o 0, mem_addr_o 0, counters 0. While reset is high, stall_o=0 and inst_o=0. The data/tag arrays are not reset.
- Beat counter width is log2(LINE_WORDS); it wraps only via the state transition.

Optional Feature:
- Macro: INST_CACHE_STATS_EN.
- Defined:
  - hit_cnt_o increments each cycle with hit.
  - miss_cnt_o increments once per IDLE→REFILL transition.
  - Both saturate at 32'hFFFFFFFF.
- Undefined: both ports are tied to 0 and no counter flops exist.

Decomposition:
- Shared package/include: WORD, ADDR, FSM state encodings (IDLE=2'd0, REFILL=2'd1, DONE=2'd2), and the derived OFF_BITS/IDX_BITS/TAG_BITS via clog2 function.
- One natural sub-module: inst_cache_refill (FSM, beat counter, mem handshake, line-write strobes). The top holds the arrays, lookup and counters.

Test Plan:
- Reset then req_i=1, pc_i=0x40, single-cycle acks returning data 0x1000+addr → stall_o high 6 cycles, mem_addr_o 0x40..0x43 in order, then inst_o=0x1040 with stall_o=0.
- Sequential pc 0x40..0x43 after the fill → 4 consecutive hits, stall_o=0, inst_o 0x1040..0x1043, hit_cnt_o=4 with INST_CACHE_STATS_EN.
- Conflict: fill 0x40, then pc 0x140 (same idx 0) → miss and refill. Return to 0x40 → miss again, miss_cnt_o=3.
- Refill with mem_ack_i delayed 3 cycles per beat, pc_i changed to 0x80 mid-refill → line 0x40 completes with mem_addr_o held steady per beat, then 0x80 misses and refills.
- inval_i pulse in IDLE after filling 0x40 and 0x80 → next access to either misses. inval_i during refill of 0x80 → 0x80 hits afterwards and 0x40 misses.
- Assert reset during REFILL beat 2 → mem_req_o=0 immediately. After release, pc 0x40 misses and refills from beat 0.

Source files
------------

// File: rtl/inst_cache_pkg.sv
// Shared sizing, address-split widths and refill FSM encoding for the instruction cache.
package inst_cache_pkg;

    localparam int WORD       = 32;
    localparam int ADDR       = 32;
    localparam int LINES      = 16;
    localparam int LINE_WORDS = 4;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

    localparam int OFF_BITS  = clog2(LINE_WORDS);
    localparam int IDX_BITS  = clog2(LINES);
    localparam int TAG_BITS  = ADDR - OFF_BITS - IDX_BITS;
    localparam int LINE_BITS = ADDR - OFF_BITS;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REFILL = 2'd1,
        ST_DONE   = 2'd2
    } state_t;

endpackage

// File: rtl/inst_cache_refill.sv
// Line refill sequencer: one beat per mem_ack_i, registered request/address held until acked.
// Busy for LINE_WORDS acked beats plus one DONE cycle; waits indefinitely on a slow backing memory.
module inst_cache_refill
    import inst_cache_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_start,
    input  logic [LINE_BITS-1:0] i_line,
    input  logic                 i_mem_ack,
    output logic                 o_idle,
    output logic                 o_done,
    output logic                 o_wr_en,
    output logic [OFF_BITS-1:0]  o_wr_beat,
    output logic [LINE_BITS-1:0] o_line,
    output logic                 o_mem_req,
    output logic [ADDR-1:0]      o_mem_addr
);

    localparam logic [OFF_BITS-1:0] BEAT_LAST = OFF_BITS'(LINE_WORDS - 1);

    state_t               r_state;
    state_t               w_next;
    logic [OFF_BITS-1:0]  r_beat;
    logic [OFF_BITS-1:0]  w_beat_inc;
    logic [LINE_BITS-1:0] r_line;
    logic                 r_mem_req;
    logic [ADDR-1:0]      r_mem_addr;

    assign w_beat_inc = r_beat + OFF_BITS'(1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= ST_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start) w_next = ST_REFILL;
            ST_REFILL: if (i_mem_ack && (r_beat == BEAT_LAST)) w_next = ST_DONE;
            ST_DONE:   w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_beat     <= '0;
            r_line     <= '0;
            r_mem_req  <= 1'b0;
            r_mem_addr <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_line     <= i_line;
                        r_beat     <= '0;
                        r_mem_req  <= 1'b1;
                        r_mem_addr <= {i_line, {OFF_BITS{1'b0}}};
                    end
                end
                ST_REFILL: begin
                    if (i_mem_ack) begin
                        if (r_beat == BEAT_LAST) begin
                            r_beat    <= '0;
                            r_mem_req <= 1'b0;
                        end else begin
                            r_beat     <= w_beat_inc;
                            r_mem_addr <= {r_line, w_beat_inc};
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // Acks arriving outside REFILL never reach the data array.
    assign o_wr_en    = (r_state == ST_REFILL) && i_mem_ack;
    assign o_wr_beat  = r_beat;
    assign o_idle     = (r_state == ST_IDLE);
    assign o_done     = (r_state == ST_DONE);
    assign o_line     = r_line;
    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;

endmodule

// File: rtl/inst_cache.sv
// Direct-mapped instruction cache: same-cycle hit, combinational stall on miss, line refill via inst_cache_refill.
// Hit/miss counters exist only when INST_CACHE_STATS_EN is defined; otherwise the count ports read 0.
module inst_cache
    import inst_cache_pkg::*;
(
    input  logic            clk,
    input  logic            reset,
    input  logic            req_i,
    input  logic [ADDR-1:0] pc_i,
    output logic [WORD-1:0] inst_o,
    output logic            stall_o,
    input  logic            inval_i,
    output logic            mem_req_o,
    output logic [ADDR-1:0] mem_addr_o,
    input  logic            mem_ack_i,
    input  logic [WORD-1:0] mem_data_i,
    output logic [31:0]     hit_cnt_o,
    output logic [31:0]     miss_cnt_o
);

    logic [LINES-1:0]    r_valid;
    logic [TAG_BITS-1:0] r_tag  [LINES];
    logic [WORD-1:0]     r_data [LINES][LINE_WORDS];

    logic [OFF_BITS-1:0]  w_off;
    logic [IDX_BITS-1:0]  w_idx;
    logic [TAG_BITS-1:0]  w_tag;
    logic                 w_idle;
    logic                 w_hit;
    logic                 w_miss_start;
    logic                 w_done;
    logic                 w_wr_en;
    logic [OFF_BITS-1:0]  w_wr_beat;
    logic [LINE_BITS-1:0] w_line;
    logic [IDX_BITS-1:0]  w_fill_idx;
    logic [TAG_BITS-1:0]  w_fill_tag;

    assign w_off        = pc_i[OFF_BITS-1:0];
    assign w_idx        = pc_i[OFF_BITS +: IDX_BITS];
    assign w_tag        = pc_i[ADDR-1 -: TAG_BITS];
    assign w_fill_idx   = w_line[IDX_BITS-1:0];
    assign w_fill_tag   = w_line[LINE_BITS-1 -: TAG_BITS];

    assign w_hit        = req_i && r_valid[w_idx] && (r_tag[w_idx] == w_tag) && w_idle;
    assign w_miss_start = req_i && !w_hit && w_idle;
    assign inst_o       = w_hit ? r_data[w_idx][w_off] : '0;
    assign stall_o      = req_i && !w_hit && !reset;

    inst_cache_refill u_refill (
        .clk        (clk),
        .reset      (reset),
        .i_start    (w_miss_start),
        .i_line     (pc_i[ADDR-1:OFF_BITS]),
        .i_mem_ack  (mem_ack_i),
        .o_idle     (w_idle),
        .o_done     (w_done),
        .o_wr_en    (w_wr_en),
        .o_wr_beat  (w_wr_beat),
        .o_line     (w_line),
        .o_mem_req  (mem_req_o),
        .o_mem_addr (mem_addr_o)
    );

    // Later assignments win: a line finishing in DONE survives a coincident invalidate.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_valid <= '0;
        end else begin
            if (inval_i)      r_valid <= '0;
            if (w_miss_start) r_valid[w_idx] <= 1'b0;
            if (w_done)       r_valid[w_fill_idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (w_wr_en) r_data[w_fill_idx][w_wr_beat] <= mem_data_i;
        if (w_done)  r_tag[w_fill_idx] <= w_fill_tag;
    end

`ifdef INST_CACHE_STATS_EN
    logic [31:0] r_hit_cnt;
    logic [31:0] r_miss_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hit_cnt  <= '0;
            r_miss_cnt <= '0;
        end else begin
            if (w_hit && (r_hit_cnt != 32'hFFFF_FFFF))         r_hit_cnt  <= r_hit_cnt + 32'd1;
            if (w_miss_start && (r_miss_cnt != 32'hFFFF_FFFF)) r_miss_cnt <= r_miss_cnt + 32'd1;
        end
    end

    assign hit_cnt_o  = r_hit_cnt;
    assign miss_cnt_o = r_miss_cnt;
`else
    assign hit_cnt_o  = '0;
    assign miss_cnt_o = '0;
`endif

endmodule

// File: tb/tb_inst_cache.sv
// Directed bench for inst_cache: backing memory returns 0x1000+addr with a programmable ack delay.
module tb_inst_cache;

    logic        clk;
    logic        reset;
    logic        req_i;
    logic [31:0] pc_i;
    logic [31:0] inst_o;
    logic        stall_o;
    logic        inval_i;
    logic        mem_req_o;
    logic [31:0] mem_addr_o;
    logic        mem_ack_i;
    logic [31:0] mem_data_i;
    logic [31:0] hit_cnt_o;
    logic [31:0] miss_cnt_o;

`ifdef INST_CACHE_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    int vectors;
    int fails;

    int          ack_delay;
    int          wait_cnt;
    logic [31:0] beats[$];
    bit          prev_wait;
    logic [31:0] prev_addr;
    int          unstable;

    inst_cache dut (
        .clk        (clk),
        .reset      (reset),
        .req_i      (req_i),
        .pc_i       (pc_i),
        .inst_o     (inst_o),
        .stall_o    (stall_o),
        .inval_i    (inval_i),
        .mem_req_o  (mem_req_o),
        .mem_addr_o (mem_addr_o),
        .mem_ack_i  (mem_ack_i),
        .mem_data_i (mem_data_i),
        .hit_cnt_o  (hit_cnt_o),
        .miss_cnt_o (miss_cnt_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    assign mem_ack_i  = mem_req_o && (wait_cnt >= ack_delay);
    assign mem_data_i = 32'h1000 + mem_addr_o;

    always @(posedge clk) begin
        if (!mem_req_o || mem_ack_i) wait_cnt <= 0;
        else                         wait_cnt <= wait_cnt + 1;
    end

    always @(negedge clk) begin
        if (mem_ack_i) beats.push_back(mem_addr_o);
        if (prev_wait && mem_req_o && (mem_addr_o != prev_addr)) unstable = unstable + 1;
        prev_wait = mem_req_o && !mem_ack_i;
        prev_addr = mem_addr_o;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_q(input string tag, input logic [31:0] b0, input logic [31:0] b1, input int nl);
        chk({tag, "_count"}, 32'(beats.size()), 32'(4 * nl));
        for (int i = 0; i < 4 * nl && i < beats.size(); i++)
            chk(tag, beats[i], (i < 4) ? b0 + 32'(i) : b1 + 32'(i - 4));
    endtask

    task automatic run_fetch(input logic [31:0] pc, input int exp_stalls,
                             input int redir_at = -1, input logic [31:0] pc2 = 32'h0,
                             input int inval_at = -1);
        int n;
        bit done;
        beats.delete();
        @(posedge clk); #1;
        req_i   = 1'b1;
        pc_i    = pc;
        inval_i = 1'b0;
        n       = 0;
        done    = 1'b0;
        while (!done) begin
            @(negedge clk);
            if (!stall_o) begin
                done = 1'b1;
            end else begin
                n++;
                if (n > 400) begin
                    done = 1'b1;
                end else begin
                    @(posedge clk); #1;
                    inval_i = (n == inval_at);
                    if (n == redir_at) pc_i = pc2;
                end
            end
        end
        inval_i = 1'b0;
        chk($sformatf("stall_cycles_%0h", pc), 32'(n), 32'(exp_stalls));
        chk($sformatf("inst_%0h", pc_i), inst_o, 32'h1000 + pc_i);
    endtask

    task automatic inval_pulse();
        @(posedge clk); #1;
        req_i   = 1'b0;
        inval_i = 1'b1;
        @(posedge clk); #1;
        inval_i = 1'b0;
    endtask

    task automatic idle_counts(input string tag, input int hits, input int misses);
        @(posedge clk); #1;
        req_i = 1'b0;
        @(negedge clk);
        chk({tag, "_stall_idle"}, 32'(stall_o), 32'd0);
        chk({tag, "_inst_idle"}, inst_o, 32'd0);
        chk({tag, "_hit_cnt"}, hit_cnt_o, STATS ? 32'(hits) : 32'd0);
        chk({tag, "_miss_cnt"}, miss_cnt_o, STATS ? 32'(misses) : 32'd0);
    endtask

    initial begin
        vectors   = 0;
        fails     = 0;
        unstable  = 0;
        ack_delay = 0;
        reset     = 1'b1;
        req_i     = 1'b1;
        pc_i      = 32'h40;
        inval_i   = 1'b0;

        // Reset state with a pending request
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stall", 32'(stall_o), 32'd0);
        chk("rst_inst", inst_o, 32'd0);
        chk("rst_mem_req", 32'(mem_req_o), 32'd0);
        chk("rst_mem_addr", mem_addr_o, 32'd0);
        chk("rst_hit_cnt", hit_cnt_o, 32'd0);
        chk("rst_miss_cnt", miss_cnt_o, 32'd0);
        reset = 1'b0;
        req_i = 1'b0;

        // Cold miss then sequential hits in the same line
        run_fetch(32'h40, 6);
        check_q("beats_a", 32'h40, 32'h0, 1);
        for (int p = 32'h41; p <= 32'h43; p++) begin
            @(posedge clk); #1;
            pc_i = 32'(p);
            @(negedge clk);
            chk($sformatf("seq_stall_%0h", p), 32'(stall_o), 32'd0);
            chk($sformatf("seq_inst_%0h", p), inst_o, 32'h1000 + 32'(p));
        end
        idle_counts("a", 4, 1);

        // Conflict on index 0
        run_fetch(32'h140, 6);
        run_fetch(32'h40, 6);
        idle_counts("b", 6, 3);

        // Slow acks with a branch redirect mid-refill
        inval_pulse();
        ack_delay = 3;
        run_fetch(32'h40, 36, 5, 32'h80);
        check_q("beats_c", 32'h40, 32'h80, 2);
        chk("addr_stable", 32'(unstable), 32'd0);
        ack_delay = 0;

        // Invalidate while idle
        run_fetch(32'h44, 6);
        inval_pulse();
        run_fetch(32'h80, 6);
        run_fetch(32'h44, 6);

        // Invalidate during refill and coincident with DONE
        run_fetch(32'h40, 6);
        run_fetch(32'h80, 6, -1, 32'h0, 2);
        run_fetch(32'h80, 0);
        run_fetch(32'h44, 6);
        run_fetch(32'h4C, 6, -1, 32'h0, 5);
        run_fetch(32'h4C, 0);
        run_fetch(32'h44, 6);
        run_fetch(32'h40, 6);

        // Reset in the middle of beat 2
        @(posedge clk); #1;
        req_i = 1'b1;
        pc_i  = 32'h88;
        @(negedge clk);
        chk("mid_stall", 32'(stall_o), 32'd1);
        repeat (3) @(posedge clk);
        #1;
        chk("mid_mem_req", 32'(mem_req_o), 32'd1);
        chk("mid_mem_addr", mem_addr_o, 32'h8A);
        reset = 1'b1;
        #1;
        chk("arst_mem_req", 32'(mem_req_o), 32'd0);
        chk("arst_mem_addr", mem_addr_o, 32'd0);
        chk("arst_stall", 32'(stall_o), 32'd0);
        chk("arst_inst", inst_o, 32'd0);
        chk("arst_hit_cnt", hit_cnt_o, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        req_i = 1'b0;
        run_fetch(32'h88, 6);
        check_q("beats_f", 32'h88, 32'h0, 1);
        run_fetch(32'h80, 6);
        idle_counts("f", 2, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
        $finish;
    end

endmodule
